relu_arbiter: RTL and testbench

Shares one ReLU activation datapath (NBITS-wide signed fixed-point, Q8.8 at default width) between NREQS requesters using round-robin arbitration. Each requester presents a pre-activation value on a val/rdy interface. The winner's value passes through the ReLU and is registered into a single output slot, tagged with the requester id. The block sits between the MAC accumulators and the activation writeback path in the NPU.

---
 rtl/relu_arbiter.sv | 127 ++++++++++++
 tb/tb_relu_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/relu_arbiter.sv
// Round-robin arbiter sharing one ReLU datapath among NREQS requesters, with a registered output slot.
// Optional clipped-input counter enabled by defining RELU_ARBITER_ZERO_COUNT_EN.
module relu_arbiter #(
    parameter int NBITS = 16,
    parameter int NREQS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQS-1:0]           req_val,
    output logic [NREQS-1:0]           req_rdy,
    input  logic [NREQS*NBITS-1:0]     req_data,
    output logic                       resp_val,
    input  logic                       resp_rdy,
    output logic [NBITS-1:0]           resp_data,
    output logic [$clog2(NREQS)-1:0]   resp_id,
    output logic [15:0]                zero_count
);

    localparam int IDW = $clog2(NREQS);

    logic             respValQ, respValD;
    logic [NBITS-1:0] respDataQ, respDataD;
    logic [IDW-1:0]   respIdQ, respIdD;
    logic [IDW-1:0]   ptrQ, ptrD;

    logic             grantValid;
    logic [IDW-1:0]   grantIdx;
    logic [NBITS-1:0] selData;
    logic [NBITS-1:0] reluData;
    logic             slotFree;
    logic             xfer;

    // Scan downward over offsets so the smallest offset from the pointer wins.
    always_comb begin
        logic [IDW:0] idx;
        grantValid = 1'b0;
        grantIdx   = '0;
        idx        = '0;
        for (int i = NREQS - 1; i >= 0; i--) begin
            idx = {1'b0, ptrQ} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NREQS)) begin
                idx = idx - (IDW+1)'(NREQS);
            end
            if (req_val[idx[IDW-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        selData = '0;
        for (int i = 0; i < NREQS; i++) begin
            if (IDW'(i) == grantIdx) begin
                selData = req_data[i*NBITS +: NBITS];
            end
        end
    end

    assign reluData = selData[NBITS-1] ? '0 : selData;
    assign slotFree = !respValQ || resp_rdy;
    assign xfer     = rst && grantValid && slotFree;

    // The ready path sees only valids, resp_rdy and reset, never the request data.
    always_comb begin
        req_rdy           = '0;
        req_rdy[grantIdx] = xfer;
    end

    always_comb begin
        respValD  = respValQ;
        respDataD = respDataQ;
        respIdD   = respIdQ;
        ptrD      = ptrQ;
        if (xfer) begin
            respValD  = 1'b1;
            respDataD = reluData;
            respIdD   = grantIdx;
            ptrD      = (grantIdx == IDW'(NREQS - 1)) ? '0 : grantIdx + 1'b1;
        end else if (resp_rdy) begin
            respValD  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            respValQ  <= 1'b0;
            respDataQ <= '0;
            respIdQ   <= '0;
            ptrQ      <= '0;
        end else begin
            respValQ  <= respValD;
            respDataQ <= respDataD;
            respIdQ   <= respIdD;
            ptrQ      <= ptrD;
        end
    end

    assign resp_val  = respValQ;
    assign resp_data = respDataQ;
    assign resp_id   = respIdQ;

`ifdef RELU_ARBITER_ZERO_COUNT_EN
    logic [15:0] zeroCountQ, zeroCountD;

    // Saturating count of transfers whose input was clipped to zero.
    always_comb begin
        zeroCountD = zeroCountQ;
        if (xfer && selData[NBITS-1] && (zeroCountQ != 16'hFFFF)) begin
            zeroCountD = zeroCountQ + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zeroCountQ <= '0;
        end else begin
            zeroCountQ <= zeroCountD;
        end
    end

    assign zero_count = zeroCountQ;
`else
    assign zero_count = 16'd0;
`endif

endmodule

// File: tb/tb_relu_arbiter.sv
// Directed table-driven bench for relu_arbiter (NBITS=16, NREQS=4).
// Expected zero_count follows RELU_ARBITER_ZERO_COUNT_EN.
module tb_relu_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_val;
    logic [3:0]  req_rdy;
    logic [63:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    logic [15:0] resp_data;
    logic [1:0]  resp_id;
    logic [15:0] zero_count;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [3:0]  reqVal;
        logic [63:0] reqData;
        logic        respRdy;
        logic [3:0]  expReqRdy;
        logic        expRespVal;
        logic [15:0] expRespData;
        logic [1:0]  expRespId;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    relu_arbiter #(.NBITS(16), .NREQS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_data   (req_data),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .zero_count (zero_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Drive one vector, check the combinational ready, clock it, then check the registered slot.
    task automatic applyStimulus(input vec_t s, input string tag);
        req_val  = s.reqVal;
        req_data = s.reqData;
        resp_rdy = s.respRdy;
        #1;
        checkOutput({tag, ".req_rdy"}, 32'(req_rdy), 32'(s.expReqRdy));
        @(posedge clk);
        #1;
        checkOutput({tag, ".resp_val"}, 32'(resp_val), 32'(s.expRespVal));
        checkOutput({tag, ".resp_data"}, 32'(resp_data), 32'(s.expRespData));
        checkOutput({tag, ".resp_id"}, 32'(resp_id), 32'(s.expRespId));
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic [63:0] rd, input logic rr,
                                input logic [3:0] er, input logic ev, input logic [15:0] ed,
                                input logic [1:0] ei);
        vec_t r;
        r.reqVal = rv; r.reqData = rd; r.respRdy = rr;
        r.expReqRdy = er; r.expRespVal = ev; r.expRespData = ed; r.expRespId = ei;
        return r;
    endfunction

    initial begin
        logic [63:0] fairData;
        logic [15:0] expZero;
        fairData = {16'h0044, 16'hFF33, 16'h0022, 16'h0011};

        // Fairness: 0,1,2,3 twice; requester 2 carries a negative value.
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(mk(4'b1111, fairData, 1'b1, 4'b0001, 1'b1, 16'h0011, 2'd0));
            vecs.push_back(mk(4'b1111, fairData, 1'b1, 4'b0010, 1'b1, 16'h0022, 2'd1));
            vecs.push_back(mk(4'b1111, fairData, 1'b1, 4'b0100, 1'b1, 16'h0000, 2'd2));
            vecs.push_back(mk(4'b1111, fairData, 1'b1, 4'b1000, 1'b1, 16'h0044, 2'd3));
        end
        // Single requester back-to-back, then drain keeps last data/id.
        vecs.push_back(mk(4'b0100, {16'h0, 16'h0100, 32'h0}, 1'b1, 4'b0100, 1'b1, 16'h0100, 2'd2));
        vecs.push_back(mk(4'b0100, {16'h0, 16'hFF00, 32'h0}, 1'b1, 4'b0100, 1'b1, 16'h0000, 2'd2));
        vecs.push_back(mk(4'b0000, 64'h0, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd2));
        // Boundaries through requester 0, with pointer wrapping back from 3.
        vecs.push_back(mk(4'b0001, {48'h0, 16'h8000}, 1'b1, 4'b0001, 1'b1, 16'h0000, 2'd0));
        vecs.push_back(mk(4'b0001, {48'h0, 16'h7FFF}, 1'b1, 4'b0001, 1'b1, 16'h7FFF, 2'd0));
        vecs.push_back(mk(4'b0001, {48'h0, 16'h0000}, 1'b1, 4'b0001, 1'b1, 16'h0000, 2'd0));
        vecs.push_back(mk(4'b0001, {48'h0, 16'hFFFF}, 1'b1, 4'b0001, 1'b1, 16'h0000, 2'd0));
        vecs.push_back(mk(4'b0000, 64'h0, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0));

        rst      = 1'b0;
        req_val  = 4'b1111;
        req_data = fairData;
        resp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.req_rdy", 32'(req_rdy), 32'h0);
        checkOutput("rst.resp_val", 32'(resp_val), 32'h0);
        checkOutput("rst.resp_data", 32'(resp_data), 32'h0);
        checkOutput("rst.resp_id", 32'(resp_id), 32'h0);
        checkOutput("rst.zero_count", 32'(zero_count), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rel.req_rdy", 32'(req_rdy), 32'b0001);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result from requester 1 held while requester 3 waits.
        applyStimulus(mk(4'b0010, {48'h0, 16'h0280, 16'h0}, 1'b1, 4'b0010, 1'b1, 16'h0280, 2'd1), "bp.load");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(mk(4'b1000, {16'h0010, 48'h0}, 1'b0, 4'b0000, 1'b1, 16'h0280, 2'd1),
                          $sformatf("bp.hold%0d", c));
        end
        applyStimulus(mk(4'b1000, {16'h0010, 48'h0}, 1'b1, 4'b1000, 1'b1, 16'h0010, 2'd3), "bp.release");

        // Asynchronous reset mid-operation with a held result discards it.
        req_val  = 4'b0001;
        req_data = {48'h0, 16'h1234};
        resp_rdy = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst.resp_val", 32'(resp_val), 32'h0);
        checkOutput("arst.resp_data", 32'(resp_data), 32'h0);
        checkOutput("arst.req_rdy", 32'(req_rdy), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Counter sequence: three negative inputs.
        applyStimulus(mk(4'b0001, {48'h0, 16'hFF00}, 1'b1, 4'b0001, 1'b1, 16'h0000, 2'd0), "cnt0");
        applyStimulus(mk(4'b0001, {48'h0, 16'h0100}, 1'b1, 4'b0001, 1'b1, 16'h0100, 2'd0), "cnt1");
        applyStimulus(mk(4'b0001, {48'h0, 16'h8000}, 1'b1, 4'b0001, 1'b1, 16'h0000, 2'd0), "cnt2");
        applyStimulus(mk(4'b0001, {48'h0, 16'h0001}, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0), "cnt3");
        applyStimulus(mk(4'b0001, {48'h0, 16'hC000}, 1'b1, 4'b0001, 1'b1, 16'h0000, 2'd0), "cnt4");
`ifdef RELU_ARBITER_ZERO_COUNT_EN
        expZero = 16'd3;
`else
        expZero = 16'd0;
`endif
        checkOutput("cnt.zero_count", 32'(zero_count), 32'(expZero));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
